instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : instruction_fetch                                             |
// | Description : Single-entry fetch register with BOOT/RUN/HALT control, flush  |
// |               on redirect and sticky fault. Optional range check enabled by  |
// |               the FETCH_BOUND_CHECK_EN macro.                                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module instruction_fetch #(
  parameter int unsigned mem_size = 256,
  parameter logic [31:0] reset_pc = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_address,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit c_bound_check = 1'b1;
`else
  localparam bit c_bound_check = 1'b0;
`endif

  localparam logic [32:0] c_mem_bytes = 33'(mem_size) * 33'd4;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_valid, w_valid_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_opc, w_opc_next;
  logic [31:0] r_opc4, w_opc4_next;
  logic        r_fault, w_fault_next;

  logic        w_capture_slot;
  logic        w_tgt_misaligned;
  logic        w_tgt_oob;
  logic        w_pc_oob;

  assign w_capture_slot   = !r_valid || out_ready;
  assign w_tgt_misaligned = (redirect_target[1:0] != 2'b00);
  assign w_tgt_oob        = ({1'b0, redirect_target} >= c_mem_bytes);
  assign w_pc_oob         = ({1'b0, r_pc} >= c_mem_bytes);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= reset_pc;
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_opc   <= 32'h0;
      r_opc4  <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      r_instr <= w_instr_next;
      r_opc   <= w_opc_next;
      r_opc4  <= w_opc4_next;
      r_fault <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_instr_next = r_instr;
    w_opc_next   = r_opc;
    w_opc4_next  = r_opc4;
    w_fault_next = r_fault;
    case (r_state)
      BOOT: begin
        w_valid_next = 1'b0;
        w_state_next = RUN;
      end
      RUN: begin
        // Redirect wins over both stall and capture; the old word is flushed.
        if (redirect) begin
          w_valid_next = 1'b0;
          if (w_tgt_misaligned || (c_bound_check && w_tgt_oob)) begin
            w_state_next = HALT;
            w_fault_next = 1'b1;
          end else begin
            w_pc_next = redirect_target;
          end
        end else if (w_capture_slot) begin
          if (c_bound_check && w_pc_oob) begin
            w_state_next = HALT;
            w_fault_next = 1'b1;
            w_valid_next = 1'b0;
          end else begin
            w_instr_next = instruction;
            w_opc_next   = r_pc;
            w_opc4_next  = r_pc + 32'd4;
            w_valid_next = 1'b1;
            w_pc_next    = r_pc + 32'd4;
          end
        end
      end
      HALT: begin
        w_valid_next = 1'b0;
        w_fault_next = 1'b1;
      end
      default: begin
        w_state_next = HALT;
        w_valid_next = 1'b0;
        w_fault_next = 1'b1;
      end
    endcase
  end

  assign read_address    = r_pc;
  assign out_valid       = r_valid;
  assign out_instruction = r_instr;
  assign out_pc          = r_opc;
  assign out_pc_plus4    = r_opc4;
  assign fault           = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Testbench for instruction_fetch: directed stimulus, cycle model compared on every
// falling edge, plus literal expectations. Honours FETCH_BOUND_CHECK_EN.
module tb_instruction_fetch;

  localparam int unsigned MEM_WORDS = 256;

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;

  logic [31:0] mem [0:MEM_WORDS-1];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.mem_size(MEM_WORDS), .reset_pc(32'h0)) dut (
    .clk(clk), .reset(reset), .read_address(read_address), .instruction(instruction),
    .redirect(redirect), .redirect_target(redirect_target), .out_ready(out_ready),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .fault(fault)
  );

  // Memory image; addresses beyond the array return a pattern derived from the address.
  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    if (addr < 32'(MEM_WORDS * 4)) return mem[addr[9:2]];
    return addr ^ 32'hDEADBEEF;
  endfunction

  assign instruction = fetch_word(read_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state of the fetch stage.
  bit          m_boot, m_halt, m_valid;
  logic [31:0] m_pc, m_instr, m_opc, m_opc4;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_boot <= 1'b1; m_halt <= 1'b0; m_valid <= 1'b0;
      m_pc <= 32'h0; m_instr <= 32'h0; m_opc <= 32'h0; m_opc4 <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_halt) begin
      if (redirect) begin
        m_valid <= 1'b0;
        if (redirect_target % 4 != 0 || (BC && redirect_target >= MEM_WORDS * 4)) m_halt <= 1'b1;
        else m_pc <= redirect_target;
      end else if (!m_valid || out_ready) begin
        if (BC && m_pc >= MEM_WORDS * 4) begin
          m_halt <= 1'b1; m_valid <= 1'b0;
        end else begin
          m_instr <= fetch_word(m_pc); m_opc <= m_pc; m_opc4 <= m_pc + 32'd4;
          m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_read_address", read_address, m_pc);
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_fault", 32'(fault), 32'(m_halt));
    check("model_out_instruction", out_instruction, m_instr);
    check("model_out_pc", out_pc, m_opc);
    check("model_out_pc_plus4", out_pc_plus4, m_opc4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h11111111 * 32'(i + 1);
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_read_address", read_address, 32'h0);
    check("rst_out_instruction", out_instruction, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h0);

    // Reset release: one BOOT cycle, then sequential capture.
    reset = 1'b0;
    tick();
    check("boot_valid", 32'(out_valid), 32'h0);
    check("boot_read_address", read_address, 32'h0);
    tick();
    check("seq0_valid", 32'(out_valid), 32'h1);
    check("seq0_pc", out_pc, 32'h0);
    check("seq0_instr", out_instruction, 32'h11111111);
    tick();
    check("seq1_pc", out_pc, 32'h4);
    check("seq1_instr", out_instruction, 32'h22222222);
    tick();
    check("seq2_pc", out_pc, 32'h8);

    // Stall for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", out_pc, 32'h8);
      check("stall_read_address", read_address, 32'hC);
      check("stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check("post_stall_pc", out_pc, 32'hC);

    // Redirect beats a stall.
    out_ready = 1'b0; redirect = 1'b1; redirect_target = 32'd32;
    tick();
    redirect = 1'b0;
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_read_address", read_address, 32'd32);
    tick();
    check("redir_pc", out_pc, 32'd32);
    check("redir_pc_plus4", out_pc_plus4, 32'd36);
    check("redir_instr", out_instruction, 32'h99999999);
    out_ready = 1'b1;

    // Target just past the memory.
    redirect = 1'b1; redirect_target = 32'd1024;
    tick();
    redirect = 1'b0;
    if (BC) begin
      check("bound_fault", 32'(fault), 32'h1);
      check("bound_valid", 32'(out_valid), 32'h0);
      tick();
      check("bound_fault_sticky", 32'(fault), 32'h1);
    end else begin
      check("nobound_read_address", read_address, 32'd1024);
      tick();
      check("nobound_pc", out_pc, 32'd1024);
      check("nobound_instr", out_instruction, 32'hDEADBAEF);
      check("nobound_fault", 32'(fault), 32'h0);
    end

    reset = 1'b1; tick(); reset = 1'b0; tick();

    if (!BC) begin
      redirect = 1'b1; redirect_target = 32'hFFFFFFF8;
      tick();
      redirect = 1'b0;
      tick();
      check("wrap_pc0", out_pc, 32'hFFFFFFF8);
      tick();
      check("wrap_pc1", out_pc, 32'hFFFFFFFC);
      check("wrap_pc_plus4", out_pc_plus4, 32'h0);
      tick();
      check("wrap_pc2", out_pc, 32'h0);
      check("wrap_fault", 32'(fault), 32'h0);
      reset = 1'b1; tick(); reset = 1'b0; tick();
    end

    // Misaligned redirect halts; later redirects and ready are ignored.
    redirect = 1'b1; redirect_target = 32'h22;
    tick();
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_valid", 32'(out_valid), 32'h0);
    check("mis_read_address", read_address, 32'h0);
    redirect_target = 32'd64;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      tick();
      check("halt_fault", 32'(fault), 32'h1);
      check("halt_valid", 32'(out_valid), 32'h0);
      check("halt_read_address", read_address, 32'h0);
    end
    redirect = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("halt_reset_fault", 32'(fault), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("halt_reset_pc", read_address, 32'h0);
    check("halt_reset_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset in the middle of a stall.
    tick(); tick();
    check("pre_async_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_out_pc", out_pc, 32'h0);
    check("async_instr", out_instruction, 32'h0);
    check("async_read_address", read_address, 32'h0);
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    check("after_async_pc", out_pc, 32'h0);
    check("after_async_valid", 32'(out_valid), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
